// File: rtl/i2c_slave_target.sv
// I2C target with fixed 7-bit address: strobed write bytes out, parallel read bytes in.
// Optional 3-sample majority glitch filter on SCL/SDA: define I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave_target #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK, S_WAIT_STOP
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [7:0]  shift_q;
  logic        rw_q;
  logic        sda_oe_q;
  logic [1:0]  scl_sync_q, sda_sync_q;
  logic        scl_prev_q, sda_prev_q;
  logic        scl_cond, sda_cond;
  logic        scl_rise, scl_fall, start_det, stop_det;

  // Open-drain: only ever pull low; reset clears sda_oe_q asynchronously
  assign i2c_sda = sda_oe_q ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], i2c_scl};
      sda_sync_q <= {sda_sync_q[0], i2c_sda};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;
  logic       scl_flt_q, sda_flt_q;

  // Majority of the two previous samples and the current one
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_flt_q  <= 1'b1;
      sda_flt_q  <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
      scl_flt_q  <= (scl_hist_q[1] & scl_hist_q[0]) | (scl_hist_q[1] & scl_sync_q[1]) |
                    (scl_hist_q[0] & scl_sync_q[1]);
      sda_flt_q  <= (sda_hist_q[1] & sda_hist_q[0]) | (sda_hist_q[1] & sda_sync_q[1]) |
                    (sda_hist_q[0] & sda_sync_q[1]);
    end
  end

  assign scl_cond = scl_flt_q;
  assign sda_cond = sda_flt_q;
`else
  assign scl_cond = scl_sync_q[1];
  assign sda_cond = sda_sync_q[1];
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_cond;
      sda_prev_q <= sda_cond;
    end
  end

  assign scl_rise  =  scl_cond & ~scl_prev_q;
  assign scl_fall  = ~scl_cond &  scl_prev_q;
  assign start_det =  scl_cond &  scl_prev_q &  sda_prev_q & ~sda_cond;
  assign stop_det  =  scl_cond &  scl_prev_q & ~sda_prev_q &  sda_cond;

  // Protocol FSM; bus conditions take priority over any bit activity
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      shift_q  <= 8'h00;
      rw_q     <= 1'b0;
      sda_oe_q <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      if (start_det) begin
        state_q  <= S_ADDR;
        cnt_q    <= 4'd0;
        sda_oe_q <= 1'b0;
      end else if (stop_det) begin
        state_q  <= S_IDLE;
        cnt_q    <= 4'd0;
        sda_oe_q <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state_q)
          S_ADDR: if (scl_rise) begin
            shift_q <= {shift_q[6:0], sda_cond};
            if (cnt_q == 4'd7) begin
              cnt_q <= 4'd0;
              if (shift_q[6:0] == SLAVE_ADDR) begin
                state_q <= S_ADDR_ACK;
                busy    <= 1'b1;
                rw_q    <= sda_cond;
              end else begin
                state_q <= S_WAIT_STOP;
                busy    <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          S_ADDR_ACK, S_RX_ACK: if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              sda_oe_q <= 1'b1;
              cnt_q    <= 4'd1;
            end else begin
              cnt_q <= 4'd0;
              if (state_q == S_ADDR_ACK && rw_q) begin
                // First read bit goes out on the same edge that ends the ACK
                shift_q  <= {tx_data[6:0], 1'b0};
                sda_oe_q <= ~tx_data[7];
                tx_req   <= 1'b1;
                state_q  <= S_TX;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= S_RX;
              end
            end
          end
          S_RX: if (scl_rise) begin
            shift_q <= {shift_q[6:0], sda_cond};
            if (cnt_q == 4'd7) begin
              rx_data  <= {shift_q[6:0], sda_cond};
              rx_valid <= 1'b1;
              cnt_q    <= 4'd0;
              state_q  <= S_RX_ACK;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          S_TX: if (scl_fall) begin
            if (cnt_q == 4'd7) begin
              sda_oe_q <= 1'b0;
              cnt_q    <= 4'd0;
              state_q  <= S_TX_ACK;
            end else begin
              sda_oe_q <= ~shift_q[7];
              shift_q  <= {shift_q[6:0], 1'b0};
              cnt_q    <= cnt_q + 4'd1;
            end
          end
          S_TX_ACK: begin
            if (scl_rise) begin
              if (sda_cond) state_q <= S_WAIT_STOP;
              else          cnt_q   <= 4'd1;
            end else if (scl_fall && cnt_q == 4'd1) begin
              shift_q  <= {tx_data[6:0], 1'b0};
              sda_oe_q <= ~tx_data[7];
              tx_req   <= 1'b1;
              cnt_q    <= 4'd0;
              state_q  <= S_TX;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_target.sv
// Bench for i2c_slave_target: bit-banged master, address/data model and rx scoreboard.
module tb_i2c_slave_target;
  localparam logic [6:0] ADDR = 7'h50;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, busy;
  wire        sda_bus;

  assign sda_bus = m_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_slave_target #(.SLAVE_ADDR(ADDR)) dut (
    .clk(clk), .resetN(resetN), .i2c_scl(scl), .i2c_sda(sda_bus),
    .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_req(tx_req), .busy(busy)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] rx_exp[$];
  logic [7:0] tx_vals[4];
  int         tx_idx = 0;
  int         tx_req_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard monitor plus the upstream byte source that advances on tx_req
  always @(negedge clk) begin
    if (rx_valid) begin
      if (rx_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got %0h expected no strobe", rx_data);
      end else begin
        chk("rx_data", 32'(rx_data), 32'(rx_exp.pop_front()));
      end
    end
    if (tx_req) begin
      tx_req_cnt++;
      tx_idx++;
      tx_data = (tx_idx < 4) ? tx_vals[tx_idx] : 8'hEE;
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_io(input logic b, input logic glitch, output logic rd);
    m_low = !b;
    wclk(5);
    scl = 1'b1;
    if (glitch) begin
      wclk(2); scl = 1'b0; wclk(1); scl = 1'b1; wclk(2);
    end else begin
      wclk(5);
    end
    rd = (sda_bus !== 1'b0);
    wclk(5);
    scl = 1'b0;
    wclk(5);
  endtask

  task automatic start_c();
    m_low = 1'b1; wclk(5); scl = 1'b0; wclk(5);
  endtask

  task automatic rstart_c();
    m_low = 1'b0; wclk(5); scl = 1'b1; wclk(5); m_low = 1'b1; wclk(5); scl = 1'b0; wclk(5);
  endtask

  task automatic stop_c();
    m_low = 1'b1; wclk(5); scl = 1'b1; wclk(5); m_low = 1'b0; wclk(10);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic glitch, output logic ack);
    logic rd;
    for (int i = 7; i >= 0; i--) bit_io(b[i], glitch && (i == 3), rd);
    bit_io(1'b1, 1'b0, rd);
    ack = !rd;
  endtask

  task automatic recv_byte(input logic m_ack, output logic [7:0] b);
    logic rd;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, 1'b0, rd);
      b[i] = rd;
    end
    bit_io(!m_ack, 1'b0, rd);
  endtask

  task automatic do_write(input logic [6:0] a, input int n, input logic [31:0] data,
                          input logic rep, input logic do_stop, input logic glitch);
    logic       ack;
    logic       match;
    logic [7:0] b;
    match = (a == ADDR);
    if (rep) rstart_c(); else start_c();
    send_byte({a, 1'b0}, 1'b0, ack);
    chk("wr_addr_ack", 32'(ack), 32'(match));
    chk("wr_busy", 32'(busy), 32'(match));
    for (int i = 0; i < n; i++) begin
      b = data[8*i +: 8];
      if (match) rx_exp.push_back(b);
      send_byte(b, glitch, ack);
      chk("wr_data_ack", 32'(ack), 32'(match));
    end
    if (do_stop) begin
      stop_c();
      chk("busy_after_stop", 32'(busy), 32'd0);
    end
  endtask

  task automatic do_read(input logic [6:0] a, input int n, input logic [31:0] data,
                         input logic rep);
    logic       ack;
    logic       match;
    logic [7:0] b;
    match = (a == ADDR);
    for (int i = 0; i < 4; i++) tx_vals[i] = data[8*i +: 8];
    tx_idx = 0;
    tx_data = tx_vals[0];
    tx_req_cnt = 0;
    if (rep) rstart_c(); else start_c();
    send_byte({a, 1'b1}, 1'b0, ack);
    chk("rd_addr_ack", 32'(ack), 32'(match));
    if (match) begin
      for (int i = 0; i < n; i++) begin
        recv_byte(i < n - 1, b);
        chk("rd_data", 32'(b), 32'(tx_vals[i]));
      end
      wclk(2);
      chk("sda_rel_after_nack", 32'(sda_bus !== 1'b0), 32'd1);
      chk("rd_busy", 32'(busy), 32'd1);
    end
    chk("tx_req_cnt", 32'(tx_req_cnt), match ? 32'(n) : 32'd0);
    stop_c();
    chk("busy_after_stop", 32'(busy), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic       rd;
    logic [6:0] a;
    int         n;
    wclk(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_tx_req", 32'(tx_req), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_sda", 32'(sda_bus !== 1'b0), 32'd1);
    resetN = 1'b1;
    wclk(10);

    do_write(ADDR, 1, 32'h0000_00A5, 1'b0, 1'b1, 1'b0);
    do_read(ADDR, 2, 32'h0000_C33C, 1'b0);
    do_write(7'h51, 1, 32'h0000_00FF, 1'b0, 1'b1, 1'b0);
    do_write(ADDR, 1, 32'h0000_0011, 1'b0, 1'b0, 1'b0);
    do_read(ADDR, 1, $urandom, 1'b1);

    // Reset mid-read while the target is pulling SDA low for a 0 bit
    for (int i = 0; i < 4; i++) tx_vals[i] = 8'h00;
    tx_idx = 0;
    tx_data = 8'h00;
    start_c();
    send_byte({ADDR, 1'b1}, 1'b0, rd);
    for (int i = 0; i < 3; i++) bit_io(1'b1, 1'b0, rd);
    m_low = 1'b0;
    wclk(5);
    scl = 1'b1;
    wclk(3);
    chk("sda_driven_before_rst", 32'(sda_bus !== 1'b0), 32'd0);
    resetN = 1'b0;
    #1;
    chk("sda_rel_on_rst", 32'(sda_bus !== 1'b0), 32'd1);
    chk("busy_on_rst", 32'(busy), 32'd0);
    wclk(3);
    resetN = 1'b1;
    wclk(10);
    do_write(ADDR, 1, $urandom, 1'b0, 1'b1, 1'b0);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    do_write(ADDR, 2, 32'h0000_5AC7, 1'b0, 1'b1, 1'b1);
`endif

    for (int t = 0; t < 12; t++) begin
      a = ADDR;
      if ($urandom_range(0, 3) == 0) begin
        a = 7'($urandom_range(0, 127));
        if (a == ADDR) a = ADDR ^ 7'h01;
      end
      n = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1) do_read(a, n, $urandom, 1'b0);
      else do_write(a, n, $urandom, 1'b0, 1'b1, 1'b0);
    end

    wclk(10);
    chk("rx_exp_drained", 32'(rx_exp.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
